// File: rtl/bitserial_result_collector_if.sv
// Bus interface for bitserial_result_collector: the bit-serial lane input
// handshake and the single BRAM write port.
//
// Lane handshake: lane_bits moves from source to collector on a rising clock
// edge where lane_valid && in_ready. While in_ready is low the source must
// hold lane_bits/lane_valid stable; in_ready does not depend on lane_valid.
interface bitserial_result_collector_if #(
  parameter int LANES    = 4,
  parameter int WORD_LEN = 16,
  parameter int ADDR_W   = 10
);
  logic [LANES-1:0]    lane_bits;
  logic                lane_valid;
  logic                in_ready;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [WORD_LEN-1:0] din;

  // master: lane source / BRAM sink side; slave: the collector
  modport master (output lane_bits, lane_valid, input in_ready, we, addr, din);
  modport slave  (input lane_bits, lane_valid, output in_ready, we, addr, din);
endinterface

// File: rtl/bitserial_result_collector.sv
// bitserial_result_collector: deserialises LANES LSB-first bit-serial result
// streams into words, sign-extends them to WORD_LEN bits and writes them to a
// BRAM at consecutive addresses (base + word*LANES + lane, wrapping).
// Optional macro COLLECT_OVERRUN_EN adds a sticky 'overrun' flag for lane
// data offered while the collector is busy but not ready.
module bitserial_result_collector #(
  parameter int LANES    = 4,
  parameter int WORD_LEN = 16,
  parameter int ADDR_W   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4:0]           len,
  input  logic [7:0]           num_words,
  input  logic [ADDR_W-1:0]    base_addr,
  bitserial_result_collector_if.slave bus,
  output logic                 busy,
  output logic                 done,
`ifdef COLLECT_OVERRUN_EN
  output logic                 overrun,
`endif
  output logic [1:0]           state_dbg
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, WRITE = 2'd2, FINISH = 2'd3} state_t;

  state_t                              state_q, state_d;
  logic [4:0]                          len_q, len_d;
  logic [7:0]                          num_q, num_d;
  logic [ADDR_W-1:0]                   base_q, base_d;
  logic [4:0]                          bitcnt_q, bitcnt_d;
  logic [7:0]                          word_q, word_d;
  logic [LW-1:0]                       lane_q, lane_d;
  logic [LANES-1:0][WORD_LEN-1:0]      shreg_q, shreg_d;
  logic                                in_ready_q, in_ready_d;
  logic                                we_q, we_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d;
  logic [WORD_LEN-1:0]                 din_q, din_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                overrun_q, overrun_d;
  logic                                transfer;
  logic                                len_ok;
  logic [ADDR_W-1:0]                   offset;

  // Sign-extend w from bit l-1; bits at and above l take that sign bit.
  function automatic logic [WORD_LEN-1:0] sign_extend(input logic [WORD_LEN-1:0] w,
                                                      input logic [4:0] l);
    logic                s;
    logic [WORD_LEN-1:0] r;
    s = 1'b0;
    for (int b = 0; b < WORD_LEN; b++) begin
      if (5'(b) + 5'd1 == l) s = w[b];
    end
    for (int b = 0; b < WORD_LEN; b++) begin
      r[b] = (5'(b) < l) ? w[b] : s;
    end
    return r;
  endfunction

  // Next-state, counters, shift registers and registered-output values.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    num_d      = num_q;
    base_d     = base_q;
    bitcnt_d   = bitcnt_q;
    word_d     = word_q;
    lane_d     = lane_q;
    shreg_d    = shreg_q;
    addr_d     = addr_q;
    din_d      = din_q;
    overrun_d  = overrun_q;
    offset     = '0;
    transfer   = bus.lane_valid && in_ready_q;
    len_ok     = (len != 5'd0) && (32'(len) <= WORD_LEN);

    case (state_q)
      IDLE: begin
        if (start) begin
          overrun_d = 1'b0;
          if (len_ok && (num_words != 8'd0)) begin
            len_d    = len;
            num_d    = num_words;
            base_d   = base_addr;
            bitcnt_d = '0;
            word_d   = '0;
            lane_d   = '0;
            shreg_d  = '0;
            state_d  = SHIFT;
          end else begin
            state_d  = FINISH;
          end
        end
      end
      SHIFT: begin
        if (transfer) begin
          for (int i = 0; i < LANES; i++) begin
            for (int b = 0; b < WORD_LEN; b++) begin
              if (5'(b) == bitcnt_q) shreg_d[i][b] = bus.lane_bits[i];
            end
          end
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == len_q - 5'd1) begin
            lane_d  = '0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (lane_q == LAST_LANE) begin
          lane_d = '0;
          word_d = word_q + 8'd1;
          if (word_q + 8'd1 == num_q) begin
            state_d = FINISH;
          end else begin
            bitcnt_d = '0;
            state_d  = SHIFT;
          end
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Offered data while busy and not ready is dropped; remember that it happened.
    if (bus.lane_valid && !in_ready_q && busy_q) overrun_d = 1'b1;

    // Outputs are derived from the next state so they line up with it.
    we_d       = (state_d == WRITE);
    done_d     = (state_d == FINISH);
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == SHIFT);
    if (we_d) begin
      offset = ADDR_W'(32'(word_d) * LANES + 32'(lane_d));
      addr_d = base_d + offset;
      din_d  = sign_extend(shreg_d[lane_d], len_d);
    end
  end

  // State and output registers; asynchronous reset aborts any job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      num_q      <= '0;
      base_q     <= '0;
      bitcnt_q   <= '0;
      word_q     <= '0;
      lane_q     <= '0;
      shreg_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      num_q      <= num_d;
      base_q     <= base_d;
      bitcnt_q   <= bitcnt_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
      shreg_q    <= shreg_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.addr     = addr_q;
  assign bus.din      = din_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign state_dbg    = state_q;
`ifdef COLLECT_OVERRUN_EN
  assign overrun      = overrun_q;
`else
  logic unused_overrun;
  assign unused_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_bitserial_result_collector.sv
// Self-checking bench for bitserial_result_collector.
module tb_bitserial_result_collector;
  localparam int LANES    = 4;
  localparam int WORD_LEN = 16;
  localparam int ADDR_W   = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start;
  logic [4:0]        len;
  logic [7:0]        num_words;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;
`ifdef COLLECT_OVERRUN_EN
  logic              overrun;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int done_cnt = 0;
  logic [ADDR_W+WORD_LEN-1:0] exp_q[$];

  bitserial_result_collector_if #(.LANES(LANES), .WORD_LEN(WORD_LEN), .ADDR_W(ADDR_W)) bus ();

  bitserial_result_collector #(.LANES(LANES), .WORD_LEN(WORD_LEN), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .num_words (num_words),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
`ifdef COLLECT_OVERRUN_EN
    .overrun   (overrun),
`endif
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference sign extension: shift up, arithmetic shift back down
  function automatic logic [15:0] sext(input logic [15:0] w, input int l);
    logic [15:0] t;
    t = w << (16 - l);
    return 16'($signed(t) >>> (16 - l));
  endfunction

  // scoreboard: every BRAM write is popped and compared
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.we) begin
      last_we_cyc = cyc;
      check_eq("rdy_in_wr", 32'(bus.in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexp_we", 32'(bus.addr), 32'hFFFF_FFFF);
      end else begin
        logic [ADDR_W+WORD_LEN-1:0] e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(bus.addr), 32'(e[ADDR_W+WORD_LEN-1:WORD_LEN]));
        check_eq("wr_din", 32'(bus.din), 32'(e[WORD_LEN-1:0]));
      end
    end
  end

  task automatic push_word(input logic [ADDR_W-1:0] base, input int widx, input int l,
                           input logic [LANES*16-1:0] words);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < LANES; i++) begin
      a = base + ADDR_W'(widx * LANES + i);
      exp_q.push_back({a, sext(words[i*16 +: 16], l)});
    end
  endtask

  // driver: called at posedge+1
  task automatic start_job(input int l, input int nw, input logic [ADDR_W-1:0] base);
    start = 1'b1;
    len = 5'(l);
    num_words = 8'(nw);
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // send l bits of each lane word; gap inserts an idle cycle after each bit
  task automatic send_word(input logic [LANES*16-1:0] words, input int l,
                           input bit gap, input bit hold_after);
    logic ok;
    int   guard;
    for (int b = 0; b < l; b++) begin
      bus.lane_valid = 1'b1;
      for (int i = 0; i < LANES; i++) bus.lane_bits[i] = words[i*16 + b];
      guard = 0;
      do begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk); #1;
        guard++;
      end while (!ok && guard < 200);
      if (!ok) check_eq("xfer_timeout", 32'd0, 32'd1);
      if (gap) begin
        bus.lane_valid = 1'b0;
        bus.lane_bits = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
      end
    end
    if (!hold_after) bus.lane_valid = 1'b0;
  endtask

  task automatic wait_done(input bit check_gap);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 400);
    if (!done) check_eq("done_timeout", 32'd0, 32'd1);
    else if (check_gap) check_eq("done_gap", 32'(cyc - last_we_cyc), 32'd1);
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [LANES*16-1:0] w;
  int snap;

  initial begin
    start = 1'b0; len = '0; num_words = '0; base_addr = '0;
    bus.lane_bits = '0; bus.lane_valid = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_we", 32'(bus.we), 32'd0);
    check_eq("rst_addr", 32'(bus.addr), 32'd0);
    check_eq("rst_din", 32'(bus.din), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rdy", 32'(bus.in_ready), 32'd0);
`ifdef COLLECT_OVERRUN_EN
    check_eq("rst_ovr", 32'(overrun), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // mixed-sign 8-bit words
    w = {16'h0080, 16'h007F, 16'h00FA, 16'h0005};
    push_word(10'h010, 0, 8, w);
    start_job(8, 1, 10'h010);
    check_eq("busy_run", 32'(busy), 32'd1);
    send_word(w, 8, 1'b0, 1'b0);
    wait_done(1'b1);

    // 16-bit words, 3 per lane, address wrap; a stray start mid-job is ignored
    w = {4{16'h1234}};
    for (int k = 0; k < 3; k++) push_word(10'h3FC, k, 16, w);
    start_job(16, 3, 10'h3FC);
    send_word(w, 16, 1'b0, 1'b0);
    start_job(4, 1, 10'h155);
    for (int k = 1; k < 3; k++) send_word(w, 16, 1'b0, 1'b0);
    wait_done(1'b1);

    // valid toggling; idle cycles must not advance the bit count
    w = {4{16'h000B}};
    push_word(10'h080, 0, 4, w);
    start_job(4, 1, 10'h080);
    send_word(w, 4, 1'b1, 1'b0);
    wait_done(1'b1);

    // degenerate jobs: len=0, len>WORD_LEN, num_words=0
    for (int k = 0; k < 3; k++) begin
      start_job((k == 0) ? 0 : (k == 1) ? 17 : 8, (k == 2) ? 0 : 1, 10'h000);
      @(negedge clk);
      check_eq("dg_done", 32'(done), 32'd1);
      @(negedge clk);
      check_eq("dg_done_off", 32'(done), 32'd0);
      check_eq("dg_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    // reset after 3 of 8 bits
    w = {4{16'h00A5}};
    start_job(8, 1, 10'h020);
    send_word(w, 3, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
    check_eq("mid_rst_we", 32'(bus.we), 32'd0);
    check_eq("mid_rst_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    snap = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check_eq("no_done_rst", 32'(done_cnt - snap), 32'd0);
    w = {16'h00C3, 16'h0011, 16'h0080, 16'h007E};
    push_word(10'h100, 0, 8, w);
    start_job(8, 1, 10'h100);
    send_word(w, 8, 1'b0, 1'b0);
    wait_done(1'b1);

`ifdef COLLECT_OVERRUN_EN
    // lane_valid held through a write burst
    w = {16'h0009, 16'h0003, 16'h000F, 16'h0006};
    push_word(10'h040, 0, 4, w);
    push_word(10'h040, 1, 4, {w[31:0], w[63:32]});
    start_job(4, 2, 10'h040);
    send_word(w, 4, 1'b0, 1'b1);
    send_word({w[31:0], w[63:32]}, 4, 1'b0, 1'b0);
    wait_done(1'b1);
    check_eq("ovr_set", 32'(overrun), 32'd1);
    start_job(0, 1, 10'h000);
    @(negedge clk);
    check_eq("ovr_clr", 32'(overrun), 32'd0);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bitserial_result_collector.md
Name: bitserial_result_collector

Overview:
- Receive end of the array's bit-serial east-edge output lanes.
- Deserialises LANES parallel bit-serial result streams (LSB first) into WORD_LEN-bit words.
- Sign-extends each word to 16 bits and writes it through a single BRAM write port (we/addr/din) at consecutive addresses.
- Sits between the array/activation output path and the result BRAM; sequenced by the host controller via start/done.

Parameters:
- LANES, 4, number of bit-serial result lanes collected in parallel.
- WORD_LEN, 16, maximum serial word length in bits; also the BRAM data width.
- ADDR_W, 10, BRAM address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a collection job; sampled only in IDLE.
- len  in  5  serial word length in bits, valid range 1..WORD_LEN; latched on start.
- num_words  in  8  words per lane to collect; latched on start.
- base_addr  in  ADDR_W  first BRAM address; latched on start.
- lane_bits  in  LANES  one serial bit per lane; bit i belongs to lane i.
- lane_valid  in  1  lane_bits is valid this cycle.
- in_ready  out  1  collector accepts lane_bits; a transfer occurs when lane_valid && in_ready.
- we  out  1  BRAM write enable.
- addr  out  ADDR_W  BRAM write address.
- din  out  WORD_LEN  BRAM write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a job completes.

Behaviour:
- Reset (asynchronous): state IDLE; in_ready, we, busy, done = 0; addr and din = 0; all counters and shift registers cleared. Reset mid-job aborts the job with no further writes and no done pulse.
- FSM states: IDLE, SHIFT, WRITE, FINISH.
- IDLE -> SHIFT on start when len is in 1..WORD_LEN and num_words != 0. Latches len, num_words and base_addr, and clears the bit counter, word counter and lane counter.
- IDLE -> FINISH on start when len == 0, len > WORD_LEN, or num_words == 0. No writes are issued.
- SHIFT:
  - in_ready = 1.
  - On each transfer, bit lane_bits[i] is placed at position bitcnt of lane i's shift register, and bitcnt increments.
  - When the transfer with bitcnt == len-1 completes, go to WRITE on the next cycle.
- WRITE:
  - in_ready = 0.
  - Issues LANES consecutive write cycles, one for each lane from lane 0 to lane LANES-1.
  - In each write cycle: we = 1, din = lane word sign-extended from bit len-1 to WORD_LEN bits, addr = base_addr + word_idx*LANES + lane, modulo 2^ADDR_W (address wrap is silent).
  - After lane LANES-1: word_idx increments. If word_idx == num_words go to FINISH, otherwise go to SHIFT with bitcnt = 0.
- FINISH: done = 1 for exactly one cycle, then IDLE.
- Outputs we, addr, din and done are registered.
- Timing: the first write follows the final accepted bit by 1 cycle. Each word costs len transfer cycles plus LANES write cycles.
- start while busy is ignored, and the latched parameters are unchanged.
- lane_valid while in_ready = 0 is not a transfer; the source must hold its data.
- we is never asserted outside WRITE.

Optional Feature:
- Macro: COLLECT_OVERRUN_EN.
- When defined:
  - Adds output port overrun (1 bit), reset to 0.
  - overrun is set sticky when lane_valid is high while in_ready is low and busy is high.
  - overrun clears on an accepted start.
  - The offending data is discarded, and FSM timing is unchanged.
- When undefined: no port and no logic are added; behaviour is otherwise identical.

Test Plan:
- len=8, num_words=1, base_addr=0x010, lanes stream 0x05,0xFA,0x7F,0x80 LSB first -> writes (0x010,0x0005), (0x011,0xFFFA), (0x012,0x007F), (0x013,0xFF80); done pulse 1 cycle after the last write; busy low afterwards.
- len=16, num_words=3, base_addr=0x3FC, LANES=4, constant lane words 0x1234 -> 12 writes at addresses 0x3FC..0x3FF, 0x000..0x007 (wrap), all 0x1234; in_ready=0 during each 4-cycle WRITE burst.
- lane_valid toggled 1/0 every cycle during SHIFT, len=4, word 0b1011 -> only valid cycles are accepted; writes 0xFFFB; the bit count is unaffected by idle cycles.
- start with len=0, and separately with num_words=0 -> no we; done asserted exactly 1 cycle after start.
- Assert reset for 1 cycle mid-SHIFT (after 3 of 8 bits) -> outputs zero immediately; no writes and no done; a new job after reset completes correctly.
- COLLECT_OVERRUN_EN defined: hold lane_valid=1 through a WRITE burst -> overrun=1 remains set; written data is unchanged; the next start clears overrun.
